viterbi_hard_core: RTL and testbench

Hard-decision Viterbi decoder core for the rate-1/2, K=3 (g0=111, g1=101) convolutional code. It consumes the 2-bit coded symbols emitted serially by the parallel-to-serial stage. After 8 symbols it traces back through its survivor memory and produces one decoded 8-bit byte, plus the winning path metric (an estimate of corrected channel bit errors). It sits directly downstream of the serializer and upstream of the byte sink.

---
 rtl/viterbi_hard_core.sv | 148 ++++++++++++++
 tb/tb_viterbi_hard_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_hard_core.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) code.
// Decodes fixed 8-symbol frames into one byte plus the winning path metric.
module viterbi_hard_core #(
    parameter int unsigned NUM_SYM = 8,
    parameter int unsigned PM_W    = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [1:0]         i_sym,
    output logic               o_ready,
    output logic [NUM_SYM-1:0] o_data,
    output logic [PM_W-1:0]    o_metric,
    output logic               o_valid
);

    localparam int unsigned CntW = $clog2(NUM_SYM);
    localparam logic [CntW-1:0] LastSym = CntW'(NUM_SYM - 1);
    localparam logic [PM_W-1:0] PmHalf  = {1'b1, {(PM_W-1){1'b0}}};

    typedef enum logic [1:0] {StAcs, StSel, StTb, StOut} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    sym_cnt_q;
    logic [PM_W-1:0]    pm_q [4];
    logic [3:0]         surv_q [NUM_SYM];
    logic [1:0]         tb_state_q;
    logic [CntW-1:0]    tb_cnt_q;
    logic [NUM_SYM-1:0] bits_q;
    logic [PM_W-1:0]    metric_stage_q;
    logic [NUM_SYM-1:0] data_q;
    logic [PM_W-1:0]    metric_q;

    logic [PM_W-1:0] acs_pm [4];
    logic [3:0]      acs_dec;
    logic [1:0]      min_idx;
    logic [PM_W-1:0] min_pm;

    function automatic logic [1:0] branch_metric(input logic u, input logic [1:0] p,
                                                 input logic [1:0] sym);
        logic [1:0] diff;
        diff = {u ^ p[1] ^ p[0], u ^ p[0]} ^ sym;
        return {diff[1] & diff[0], diff[1] ^ diff[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                input logic [1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + (PM_W+1)'(bm);
        return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
    endfunction

    // Next state ns is reached from {ns[0],0} or {ns[0],1} with input bit ns[1].
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] Ns = 2'(g);
        localparam logic [1:0] P0 = {Ns[0], 1'b0};
        localparam logic [1:0] P1 = {Ns[0], 1'b1};
        logic [PM_W-1:0] cand0, cand1;
        assign cand0 = sat_add(pm_q[P0], branch_metric(Ns[1], P0, i_sym));
        assign cand1 = sat_add(pm_q[P1], branch_metric(Ns[1], P1, i_sym));
        assign acs_dec[g] = cand1 < cand0;
        assign acs_pm[g]  = acs_dec[g] ? cand1 : cand0;
    end

    always_comb begin
        min_idx = 2'd0;
        min_pm  = pm_q[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_q[i] < min_pm) begin
                min_pm  = pm_q[i];
                min_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StAcs;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcs: if (i_valid && sym_cnt_q == LastSym) state_d = StSel;
            StSel: state_d = StTb;
            StTb:  if (tb_cnt_q == '0) state_d = StOut;
            StOut: state_d = StAcs;
            default: state_d = StAcs;
        endcase
    end

    always_comb begin
        o_ready = (state_q == StAcs);
        o_valid = (state_q == StOut);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sym_cnt_q      <= '0;
            tb_state_q     <= '0;
            tb_cnt_q       <= '0;
            bits_q         <= '0;
            metric_stage_q <= '0;
            data_q         <= '0;
            metric_q       <= '0;
            for (int i = 0; i < 4; i++) pm_q[i] <= (i == 0) ? '0 : PmHalf;
            for (int k = 0; k < NUM_SYM; k++) surv_q[k] <= '0;
        end else begin
            unique case (state_q)
                StAcs: begin
                    if (i_valid) begin
                        for (int i = 0; i < 4; i++) pm_q[i] <= acs_pm[i];
                        surv_q[sym_cnt_q] <= acs_dec;
                        sym_cnt_q         <= sym_cnt_q + 1'b1;
                    end
                end
                StSel: begin
                    tb_state_q     <= min_idx;
                    tb_cnt_q       <= LastSym;
                    metric_stage_q <= min_pm;
                end
                StTb: begin
                    bits_q[tb_cnt_q] <= tb_state_q[1];
                    tb_state_q       <= {tb_state_q[0], surv_q[tb_cnt_q][tb_state_q]};
                    tb_cnt_q         <= tb_cnt_q - 1'b1;
                    // Last step: publish so outputs are fresh during the pulse cycle.
                    if (tb_cnt_q == '0) begin
                        data_q   <= {bits_q[NUM_SYM-1:1], tb_state_q[1]};
                        metric_q <= metric_stage_q;
                    end
                end
                StOut: begin
                    sym_cnt_q <= '0;
                    for (int i = 0; i < 4; i++) pm_q[i] <= (i == 0) ? '0 : PmHalf;
                end
                default: ;
            endcase
        end
    end

    assign o_data   = data_q;
    assign o_metric = metric_q;

endmodule

// File: tb/tb_viterbi_hard_core.sv
// Bench for viterbi_hard_core: spec vectors, corner sequences and random frames
// checked against a brute-force maximum-likelihood model.
module tb_viterbi_hard_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [1:0] sym;
    logic       ready;
    logic [7:0] data;
    logic [4:0] metric;
    logic       out_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    viterbi_hard_core #(.NUM_SYM(8), .PM_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_sym   (sym),
        .o_ready (ready),
        .o_data  (data),
        .o_metric(metric),
        .o_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] syms;
        logic [7:0]  exp_data;
        logic [4:0]  exp_metric;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder: symbol k occupies bits [2k+1:2k] as {c0,c1}.
    function automatic logic [15:0] encode(input logic [7:0] u);
        logic [1:0]  s;
        logic [15:0] r;
        s = 2'b00;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[2*k+1] = u[k] ^ s[1] ^ s[0];
            r[2*k]   = u[k] ^ s[0];
            s        = {u[k], s[1]};
        end
        return r;
    endfunction

    function automatic int best_dist(input logic [15:0] rx);
        int best;
        best = 99;
        for (int b = 0; b < 256; b++) begin
            int d;
            d = $countones(encode(8'(b)) ^ rx);
            if (d < best) best = d;
        end
        return best;
    endfunction

    task automatic send(input logic [15:0] syms, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                valid = 1'b0;
                sym   = 2'(($urandom_range(0, 3)));
            end
            @(negedge clk);
            valid = 1'b1;
            sym   = syms[2*k +: 2];
        end
    endtask

    // Returns edges after the last accepted symbol until o_valid is seen.
    task automatic wait_out(input int start, output int lat, output int when);
        lat = start;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        when = cyc;
    endtask

    task automatic xfer(input logic [15:0] syms, input bit gaps, output logic [7:0] d,
                        output logic [4:0] m, output int lat, output logic rdy,
                        output int when);
        send(syms, gaps);
        @(negedge clk);
        valid = 1'b0;
        wait_out(0, lat, when);
        d   = data;
        m   = metric;
        rdy = ready;
    endtask

    vec_t        vecs [5];
    logic [7:0]  d;
    logic [4:0]  m;
    logic        rdy;
    int          lat;
    int          t0;
    int          t1;
    logic [15:0] rx;
    logic [7:0]  ub;
    int          seen;

    initial begin
        vecs[0] = '{16'h0000, 8'h00, 5'd0};
        vecs[1] = '{16'h003B, 8'h01, 5'd0};
        vecs[2] = '{16'h003F, 8'h01, 5'd1};
        vecs[3] = '{encode(8'hA5), 8'hA5, 5'd0};
        vecs[4] = '{encode(8'hFF), 8'hFF, 5'd0};

        rst_n = 1'b0;
        valid = 1'b0;
        sym   = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_metric", 32'(metric), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i].syms, 1'b0, d, m, lat, rdy, t0);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
            chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_metric", i), 32'(m), 32'(vecs[i].exp_metric));
            chk($sformatf("vec%0d_ready_in_out", i), 32'(rdy), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_end", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_ready_back", i), 32'(ready), 32'd1);
            chk($sformatf("vec%0d_hold", i), 32'(data), 32'(vecs[i].exp_data));
        end

        // Gaps inside a frame must not disturb PM or the symbol count.
        xfer(16'h003F, 1'b1, d, m, lat, rdy, t0);
        chk("gaps_latency", 32'(lat), 32'd9);
        chk("gaps_data", 32'(d), 32'h01);
        chk("gaps_metric", 32'(m), 32'd1);

        // Backpressure: symbols offered while busy are dropped.
        send(16'h003B, 1'b0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", j), 32'(ready), 32'd0);
            valid = 1'b1;
            sym   = 2'b11;
        end
        @(negedge clk);
        valid = 1'b0;
        wait_out(6, lat, t0);
        chk("bp_latency", 32'(lat), 32'd9);
        chk("bp_data", 32'(data), 32'h01);
        chk("bp_metric", 32'(metric), 32'd0);
        xfer(16'h003B, 1'b0, d, m, lat, rdy, t0);
        chk("bp_next_data", 32'(d), 32'h01);
        chk("bp_next_metric", 32'(m), 32'd0);

        // Reset mid-frame discards the partial frame.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid = 1'b1;
            sym   = 2'b11;
        end
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(data), 32'h00);
        chk("mid_rst_metric", 32'(metric), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid = 1'b1;
            sym   = 2'b00;
        end
        @(negedge clk);
        valid = 1'b0;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_pulse", 32'(seen), 32'd0);
        // Those four symbols were a fresh partial frame; complete it with a reset first.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(16'h003B, 1'b0, d, m, lat, rdy, t0);
        chk("mid_rst_next_data", 32'(d), 32'h01);
        chk("mid_rst_next_metric", 32'(m), 32'd0);
        @(negedge clk);

        // Back-to-back frames at minimum spacing.
        xfer(16'h0000, 1'b0, d, m, lat, rdy, t0);
        chk("b2b_first_data", 32'(d), 32'h00);
        xfer(16'h003B, 1'b0, d, m, lat, rdy, t1);
        chk("b2b_second_data", 32'(d), 32'h01);
        chk("b2b_spacing", 32'(t1 - t0), 32'd18);
        @(negedge clk);

        // Random frames against the brute-force ML model.
        for (int n = 0; n < 24; n++) begin
            ub = 8'($urandom_range(0, 255));
            rx = encode(ub);
            repeat ($urandom_range(0, 3)) rx[$urandom_range(0, 15)] ^= 1'b1;
            xfer(rx, ($urandom_range(0, 1) == 1), d, m, lat, rdy, t0);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd9);
            chk($sformatf("rnd%0d_metric", n), 32'(m), 32'(best_dist(rx)));
            chk($sformatf("rnd%0d_path_dist", n), 32'($countones(encode(d) ^ rx)),
                32'(best_dist(rx)));
            if (rx == encode(ub)) chk($sformatf("rnd%0d_clean_data", n), 32'(d), 32'(ub));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
